// File: rtl/pipe_pkg.sv
// pipe_pkg: state encodings and handshake helper shared by the elastic pipeline register.
package pipe_pkg;
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;
    // State bit positions double as the main/skid valid flags.
    localparam int unsigned ST_M_BIT = 0;
    localparam int unsigned ST_S_BIT = 1;
    function automatic logic xfer(input logic valid, input logic ready);
        return valid & ready;
    endfunction
endpackage

// File: rtl/en_flip_flop.sv
// en_flip_flop: load-enabled register with async active-low reset and sync clear, both to RESET_VAL.
module en_flip_flop #(
    parameter int unsigned          WIDTH     = 32,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] data_d, data_q;

    always_comb data_d = clr ? RESET_VAL : (en ? d : data_q);

    always_ff @(posedge clk or negedge reset)
        if (!reset) data_q <= RESET_VAL;
        else        data_q <= data_d;

    assign q = data_q;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline register with two-entry skid buffer, sync flush and registered in_ready.
// Optional stall counter output enabled by PIPE_SKID_STALL_CNT_EN.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);
    logic [1:0]       state_d, state_q;
    logic             m_valid, s_valid, in_xfer, out_xfer;
    logic             m_en, s_en, m_from_skid;
    logic [WIDTH-1:0] m_d, m_data, s_data;

    assign m_valid  = state_q[ST_M_BIT];
    assign s_valid  = state_q[ST_S_BIT];
    assign in_xfer  = xfer(in_valid, in_ready);
    assign out_xfer = xfer(m_valid, out_ready);

    always_ff @(posedge clk or negedge reset)
        if (!reset) state_q <= ST_EMPTY;
        else        state_q <= state_d;

    always_comb begin
        state_d = ST_EMPTY;
        case (state_q)
            ST_EMPTY: state_d = in_xfer ? ST_BUSY : ST_EMPTY;
            ST_BUSY:  state_d = (in_xfer && !out_xfer) ? ST_FULL :
                                (out_xfer && !in_xfer) ? ST_EMPTY : ST_BUSY;
            ST_FULL:  state_d = out_xfer ? ST_BUSY : ST_FULL;
            default:  state_d = ST_EMPTY;
        endcase
        if (flush) state_d = ST_EMPTY;
    end

    // Main register refills from the skid entry when draining FULL, else from the input.
    always_comb begin
        m_from_skid = (state_q == ST_FULL);
        m_en        = (state_q == ST_EMPTY) ? in_xfer :
                      (state_q == ST_BUSY)  ? (in_xfer && out_xfer) :
                      (state_q == ST_FULL)  ? out_xfer : 1'b0;
        s_en        = (state_q == ST_BUSY) && in_xfer && !out_xfer;
        m_d         = m_from_skid ? s_data : in_data;
    end

    en_flip_flop #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clk(clk), .reset(reset), .clr(flush), .en(m_en), .d(m_d), .q(m_data)
    );

    en_flip_flop #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk(clk), .reset(reset), .clr(flush), .en(s_en), .d(in_data), .q(s_data)
    );

    assign in_ready  = ~s_valid;
    assign out_valid = m_valid;
    assign out_data  = m_data;

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    always_comb stall_cnt_d = flush ? '0 :
                              (m_valid && !out_ready && stall_cnt_q != {CNT_W{1'b1}}) ? stall_cnt_q + 1'b1 :
                              stall_cnt_q;

    always_ff @(posedge clk or negedge reset)
        if (!reset) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;

    assign stall_cnt = stall_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed vector table plus hand-written reset/stall sequences for pipe_skid_reg.
module tb_pipe_skid_reg;
    localparam logic [31:0] RV = 32'hDEAD_BEEF;

    typedef struct {
        logic        rst_n;
        logic        fl;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [1:0]  stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(32), .RESET_VAL(RV), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_SKID_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        reset = v.rst_n; flush = v.fl; in_valid = v.iv; in_data = v.id; out_ready = v.ordy;
        @(posedge clk); #1;
        chk($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, {31'd0, v.e_ir});
        chk($sformatf("v%0d out_valid", idx), {31'd0, out_valid}, {31'd0, v.e_ov});
        chk($sformatf("v%0d out_data", idx), out_data, v.e_od);
    endtask

    initial begin
        //                   rst fl iv data    ordy ir ov exp_data
        vecs.push_back(vec_t'{0, 0, 1, 32'h55, 0,  1, 0, RV});
        vecs.push_back(vec_t'{0, 0, 1, 32'h55, 0,  1, 0, RV});
        vecs.push_back(vec_t'{1, 0, 1, 32'h55, 0,  1, 1, 32'h55});
        vecs.push_back(vec_t'{1, 0, 0, 32'h0,  1,  1, 0, 32'h55});
        vecs.push_back(vec_t'{1, 0, 1, 32'h1,  1,  1, 1, 32'h1});
        vecs.push_back(vec_t'{1, 0, 1, 32'h2,  1,  1, 1, 32'h2});
        vecs.push_back(vec_t'{1, 0, 1, 32'h3,  1,  1, 1, 32'h3});
        vecs.push_back(vec_t'{1, 0, 1, 32'h4,  1,  1, 1, 32'h4});
        vecs.push_back(vec_t'{1, 0, 0, 32'h0,  1,  1, 0, 32'h4});
        vecs.push_back(vec_t'{1, 0, 1, 32'hA,  0,  1, 1, 32'hA});
        vecs.push_back(vec_t'{1, 0, 1, 32'hB,  0,  0, 1, 32'hA});
        vecs.push_back(vec_t'{1, 0, 1, 32'hC,  0,  0, 1, 32'hA});
        vecs.push_back(vec_t'{1, 0, 0, 32'h0,  1,  1, 1, 32'hB});
        vecs.push_back(vec_t'{1, 0, 0, 32'h0,  1,  1, 0, 32'hB});
        vecs.push_back(vec_t'{1, 0, 1, 32'hA,  0,  1, 1, 32'hA});
        vecs.push_back(vec_t'{1, 0, 1, 32'hB,  0,  0, 1, 32'hA});
        vecs.push_back(vec_t'{1, 1, 1, 32'hC,  1,  1, 0, RV});
        vecs.push_back(vec_t'{1, 0, 0, 32'h0,  1,  1, 0, RV});
        vecs.push_back(vec_t'{1, 1, 1, 32'h7,  0,  1, 0, RV});
        vecs.push_back(vec_t'{1, 0, 1, 32'h8,  0,  1, 1, 32'h8});
        vecs.push_back(vec_t'{1, 0, 1, 32'h9,  1,  1, 1, 32'h9});
        vecs.push_back(vec_t'{1, 0, 0, 32'h0,  0,  1, 1, 32'h9});
        vecs.push_back(vec_t'{1, 0, 0, 'x,     0,  1, 1, 32'h9});
        #1;
        foreach (vecs[i]) apply(vecs[i], i);

        // Async reset between edges while BUSY holding 0x9.
        #3 reset = 1'b0;
        #1;
        chk("async out_valid", {31'd0, out_valid}, 32'd0);
        chk("async out_data", out_data, RV);
        chk("async in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post-reset out_valid", {31'd0, out_valid}, 32'd0);

`ifdef PIPE_SKID_STALL_CNT_EN
        begin
            logic [1:0] exp_cnt [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
            in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b0;
            @(posedge clk); #1;
            chk("stall start", {30'd0, stall_cnt}, 32'd0);
            in_valid = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                chk($sformatf("stall c%0d", i), {30'd0, stall_cnt}, {30'd0, exp_cnt[i]});
            end
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            chk("stall flush", {30'd0, stall_cnt}, 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised elastic pipeline register with valid/ready handshake on both sides, a two-entry skid buffer and a synchronous flush.
- Sits between stages of the upcoming pipelined RISC-V datapath (e.g. IF/ID, ID/EX). Gives full throughput with registered in_ready, and lets the hazard unit stall or squash a stage.
- Generalises flip_flop in three ways: adds enable/backpressure, adds flush, and adds a programmable reset value.

Parameters:
- WIDTH, 32, payload width in bits (≥1).
- RESET_VAL, 0, value loaded into out_data on reset and on flush.
- CNT_W, 16, stall-counter width; used only with PIPE_SKID_STALL_CNT_EN.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream has data.
- in_ready  output  1  block can accept; registered output.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  payload, driven directly from the main register.
- stall_cnt  output  CNT_W  present only with the macro defined.

Behaviour:
- Transfer rules: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Storage: main register (m_data, m_valid) and skid register (s_data, s_valid). out_valid = m_valid, out_data = m_data, in_ready = ~s_valid.
- Reset (reset=0, async): m_valid=0, s_valid=0, m_data=RESET_VAL, s_data=RESET_VAL, in_ready=1, out_valid=0, stall_cnt=0.
- States (2-bit): EMPTY (m=0,s=0), BUSY (m=1,s=0), FULL (m=1,s=1). The state m=0,s=1 is illegal and unreachable.
- EMPTY:
  - input transfer: m←in_data, go to BUSY.
  - otherwise stay.
- BUSY:
  - input and output transfer: m←in_data, stay in BUSY.
  - output transfer only: go to EMPTY.
  - input transfer only: s←in_data, go to FULL.
  - neither: hold.
- FULL (in_ready=0, so no input transfer):
  - output transfer: m←s_data, s_valid←0, go to BUSY.
  - otherwise hold.
- Latency: 1 cycle from input transfer to out_valid when downstream is not stalled. Throughput is 1 transfer/cycle.
- Data stability: out_data is stable while out_valid && !out_ready. Data is never dropped or duplicated.
- Flush: on the next edge go to EMPTY and load m_data/s_data with RESET_VAL. Flush has priority over any simultaneous transfer, so an input accepted in the flush cycle is discarded. in_ready is 1 on the cycle after flush.
- Reset mid-operation: immediate clear regardless of state or flush.
- in_data is sampled only on an input transfer. X on in_data while in_valid=0 must not propagate.

Optional Feature:
- Macro: PIPE_SKID_STALL_CNT_EN.
- Defined:
  - Adds the stall_cnt output, which increments on each cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W−1 (no wrap).
  - Cleared by reset and by flush.
- Undefined: stall_cnt port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package pipe_pkg:
  - state localparams ST_EMPTY=2'b00, ST_BUSY=2'b01, ST_FULL=2'b11;
  - shared handshake helper constants.
- Sub-module en_flip_flop #(WIDTH, RESET_VAL): load enable, async active-low reset to RESET_VAL, synchronous clear to RESET_VAL. Instantiated for the main and skid registers.
- The FSM and valid bits stay in pipe_skid_reg.

Test Plan:
- Reset: hold reset=0 with in_valid=1, in_data=0x55. Required: out_valid=0, out_data=RESET_VAL, in_ready=1. After release, first input transfer → out_valid=1, out_data=0x55 next cycle.
- Streaming: out_ready=1, push 0x1,0x2,0x3,0x4 on consecutive cycles. Required: same sequence on out_data on cycles 1–4, in_ready stays 1, no gaps.
- Backpressure: push 0xA then 0xB with out_ready=0. Required: FULL, in_ready=0 on the cycle after 0xB, out_data held at 0xA. Raise out_ready: 0xA then 0xB delivered, in_ready returns to 1.
- Flush priority: in FULL (0xA,0xB) assert flush together with in_valid=1, in_data=0xC. Required: next cycle out_valid=0, out_data=RESET_VAL, in_ready=1, and 0xC never appears.
- Async reset mid-stream: drop reset between clock edges while in BUSY. Required: out_valid falls immediately without waiting for a clock edge.
- With PIPE_SKID_STALL_CNT_EN and CNT_W=2: hold out_valid=1, out_ready=0 for 6 cycles. Required: stall_cnt = 1,2,3,3,3,3. Flush → 0.
